buffer_ctrl: RTL
================

// Module: buffer_ctrl
// PURPOSE
//  Pointer/occupancy controller for the K-in/J-out circular word buffer.
//  Accepts K-word write bursts and issues J-word read bursts via valid/ready.
//  Drives the buffer's ld, write_add and read_add, and tracks occupancy.
//  Sits between the upstream producer, the downstream consumer and the buffer datapath.
// PARAMETERS
//  SIZE  16              buffer depth in words; must be a power of two, >= K and >= J
//  K     4               words written per accepted input burst
//  J     4               words read per accepted output burst
//  BIT   $clog2(SIZE)    address width
//  CNTW  $clog2(SIZE+1)  occupancy counter width
// PORTS
//  clk         in   1     clock; all state updates on the rising edge
//  rst         in   1     asynchronous, active-high reset
//  clr         in   1     synchronous clear of pointers and occupancy
//  in_valid    in   1     producer presents K words on the buffer par_in
//  in_ready    out  1     controller can accept a K-word burst this cycle
//  out_valid   out  1     J words are readable on the buffer par_out
//  out_ready   in   1     consumer takes the J words this cycle
//  ld          out  1     buffer load enable
//  write_add   out  BIT   buffer write base address (wr_ptr)
//  read_add    out  BIT   buffer read base address (rd_ptr)
//  count       out  CNTW  words currently held, 0..SIZE
//  full        out  1     count == SIZE
//  empty       out  1     count == 0
//  ovf_err     out  1     sticky flag: in_valid was high while in_ready was low
// BEHAVIOUR
//  Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, ovf_err=0.
//   Resulting outputs: in_ready=1, out_valid=0, ld=0, empty=1, full=0.
//  Combinational outputs:
//   - in_ready  = (count <= SIZE-K) && !clr
//   - out_valid = (count >= J) && !clr
//   - ld        = in_valid && in_ready
//   - write_add = wr_ptr; read_add = rd_ptr
//   - full and empty decode count
//  wr = in_valid & in_ready; rd = out_valid & out_ready.
//  On the clock edge:
//   - wr:           wr_ptr <= (wr_ptr+K) mod SIZE
//   - rd:           rd_ptr <= (rd_ptr+J) mod SIZE
//   - count:        count <= count + (wr?K:0) - (rd?J:0)
//   - simultaneous: both pointers move and count changes by K-J in one cycle
//  Write latency: data is stored at the edge where ld=1.
//   It can be read from the next cycle (out_valid updates then).
//  Read latency: zero; par_out is valid in the same cycle out_valid=1.
//  Same-cycle wr and rd touch disjoint words, guaranteed by the in_ready/out_valid bounds.
//   The read returns old data; there is no bypass.
//  Wrap-around: pointers use natural BIT-bit wrap. The buffer handles words past SIZE-1 in a burst.
//  Partial bursts are not supported.
//   A count below J keeps out_valid low; free space below K keeps in_ready low.
//  clr=1: pointers and count go to 0 at the edge. While clr=1, in_ready=0 and out_valid=0, so no transfer occurs.
//   ovf_err is kept.
//  ovf_err: set at the edge when in_valid=1 and in_ready=0. Cleared only by rst.
//   Producers must hold data until in_ready; this flag is a debug aid.
//  out_ready without out_valid: ignored; no underflow and no state change.
//  Asserting rst mid-burst aborts it immediately; stored data is discarded logically.
// TESTING
//  1. After reset: count=0, empty=1, in_ready=1, out_valid=0, ld=0, write_add=0, read_add=0.
//  2. SIZE=16,K=4: 4 writes with no reads -> write_add 0,4,8,12, ld high each cycle.
//     Then full=1, in_ready=0, count=16. A 5th in_valid sets ovf_err=1.
//  3. Write 1 burst, then out_ready=1 -> out_valid rises the cycle after ld.
//     read_add=0 with the first 4 words on par_out; then count=0 and empty=1.
//  4. count=8, wr and rd in the same cycle -> count stays 8; write_add and read_add each advance by 4.
//  5. K=4,J=2, wrap: wr_ptr=12, rd_ptr=12, count=0.
//     Write -> wr_ptr=0, count=4. Two reads -> read_add 12 then 14, rd_ptr=0, count=0.
//  6. count=12, pulse clr -> next cycle count=0, pointers=0, ovf_err unchanged.
//     Async rst mid-stream -> all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/buffer_ctrl.sv
// Pointer and occupancy controller for a K-in / J-out circular word buffer.
// Accepts K-word write bursts and issues J-word read bursts.
module buffer_ctrl #(
  parameter int SIZE = 16,
  parameter int K    = 4,
  parameter int J    = 4,
  parameter int BIT  = $clog2(SIZE),
  parameter int CNTW = $clog2(SIZE + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ld,
  output logic [BIT-1:0]  write_add,
  output logic [BIT-1:0]  read_add,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty,
  output logic            ovf_err
);

  localparam logic [CNTW-1:0] SPACE_LIM = CNTW'(SIZE - K);
  localparam logic [CNTW-1:0] K_C       = CNTW'(K);
  localparam logic [CNTW-1:0] J_C       = CNTW'(J);
  localparam logic [CNTW-1:0] SIZE_C    = CNTW'(SIZE);
  localparam logic [BIT-1:0]  K_STEP    = BIT'(K);
  localparam logic [BIT-1:0]  J_STEP    = BIT'(J);

  logic [BIT-1:0]  wr_ptr;
  logic [BIT-1:0]  rd_ptr;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_nxt;
  logic            ovf_q;
  logic            wr;
  logic            rd;

  assign in_ready  = (cnt_q <= SPACE_LIM) && !clr;
  assign out_valid = (cnt_q >= J_C) && !clr;
  assign wr        = in_valid && in_ready;
  assign rd        = out_valid && out_ready;
  assign ld        = wr;
  assign write_add = wr_ptr;
  assign read_add  = rd_ptr;
  assign count     = cnt_q;
  assign full      = (cnt_q == SIZE_C);
  assign empty     = (cnt_q == '0);
  assign ovf_err   = ovf_q;

  // Bounds on in_ready/out_valid keep this free of wrap in either direction.
  always_comb begin
    cnt_nxt = cnt_q;
    if (wr) cnt_nxt = cnt_nxt + K_C;
    if (rd) cnt_nxt = cnt_nxt - J_C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (in_valid && !in_ready) ovf_q <= 1'b1;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt_q  <= '0;
      end else begin
        if (wr) wr_ptr <= wr_ptr + K_STEP;
        if (rd) rd_ptr <= rd_ptr + J_STEP;
        cnt_q <= cnt_nxt;
      end
    end
  end

endmodule
